// File: rtl/blvds_stim_gen.sv
// Purpose: periodic framed test-pattern source; four payload modes, per-frame channel tag, sticky overrun flag. Optional macro: BLVDS_STIM_CHECKSUM_EN.
// Latency: the frame's first word is valid the cycle after the oFRAME_INIT pulse; then one word per accepted cycle.
// Backpressure: valid/ready. A stalled word holds still, the period counter keeps running, and an expiry mid-frame drops the next frame.
module blvds_stim_gen #(
  parameter int DATA_W    = 18,
  parameter int PERIOD_W  = 26,
  parameter int FRAME_LEN = 16,
  parameter int CH_NUM    = 4
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iENA,
  input  logic [PERIOD_W-1:0]        iPERIOD,
  input  logic [1:0]                 iMODE,
  input  logic                       iREADY,
  output logic                       oFRAME_INIT,
  output logic [DATA_W-1:0]          oDATA,
  output logic                       oVALID,
  output logic                       oSOF,
  output logic                       oEOF,
  output logic [$clog2(CH_NUM)-1:0]  oCH,
  output logic                       oOVERRUN
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int PAY_W = DATA_W - CH_W;
  localparam int IDX_W = 8;
`ifdef BLVDS_STIM_CHECKSUM_EN
  localparam int LAST_IDX = FRAME_LEN;      // checksum word follows the payload words
`else
  localparam int LAST_IDX = FRAME_LEN - 1;
`endif

  // MSB-first 1010... pattern of the payload width
  function automatic logic [PAY_W-1:0] altPattern();
    logic [PAY_W-1:0] p;
    p = '0;
    for (int i = 0; i < PAY_W; i++) p[i] = ((PAY_W - 1 - i) % 2 == 0);
    return p;
  endfunction
  localparam logic [PAY_W-1:0] ALT_PAT = altPattern();

  typedef enum logic [1:0] {IDLE, COUNT, SEND} state_t;

  state_t            state, stateNxt;
  logic [PERIOD_W-1:0] periodCnt, periodReg;
  logic [IDX_W-1:0]  wordIdx;
  logic [PAY_W-1:0]  frameCnt;
  logic [CH_W-1:0]   chReg;
  logic [1:0]        modeReg;
  logic              overrunReg;
  logic              frameInit;
  logic              expiry, xfer, lastWord;
  logic [PAY_W-1:0]  payload, payloadOut;
  int                bitPos;
`ifdef BLVDS_STIM_CHECKSUM_EN
  logic [PAY_W-1:0]  sumReg;
`endif

  assign expiry   = (periodCnt == periodReg - PERIOD_W'(1));
  assign xfer     = (state == SEND) && iREADY;
  assign lastWord = (wordIdx == IDX_W'(LAST_IDX));

  // Next-state decode and frame-start pulse
  always_comb begin
    stateNxt  = state;
    frameInit = 1'b0;
    case (state)
      IDLE:  if (iENA && (iPERIOD != '0)) stateNxt = COUNT;
      COUNT: begin
        if (!iENA) begin
          stateNxt = IDLE;
        end else if (expiry) begin
          frameInit = 1'b1;
          stateNxt  = SEND;
        end
      end
      SEND: begin
        frameInit = expiry;   // expiry here still pulses, but that frame is dropped
        if (xfer && lastWord) stateNxt = iENA ? COUNT : IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Payload pattern for the current word, using the mode latched at frame start
  always_comb begin
    payload = '0;
    bitPos  = int'(wordIdx) % PAY_W;
    case (modeReg)
      2'd0:    payload = PAY_W'(wordIdx);
      2'd1:    payload = frameCnt;
      2'd2:    payload = wordIdx[0] ? ~ALT_PAT : ALT_PAT;
      default: payload = PAY_W'(1) << bitPos;
    endcase
  end

  // Select the checksum in place of the pattern on the trailing word
  always_comb begin
    payloadOut = payload;
`ifdef BLVDS_STIM_CHECKSUM_EN
    if (wordIdx == IDX_W'(FRAME_LEN)) payloadOut = sumReg;
`endif
  end

  // FSM state register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= stateNxt;
  end

  // Period counter: cleared in IDLE, free-running through COUNT and SEND; period latched on IDLE exit
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      periodCnt <= '0;
      periodReg <= '0;
    end else if (state == IDLE) begin
      periodCnt <= '0;
      if (stateNxt == COUNT) periodReg <= iPERIOD;
    end else if (expiry) begin
      periodCnt <= '0;
    end else begin
      periodCnt <= periodCnt + PERIOD_W'(1);
    end
  end

  // Mode capture at frame start and sticky overrun on expiry during a frame
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      modeReg    <= 2'd0;
      overrunReg <= 1'b0;
    end else begin
      if (state == COUNT && stateNxt == SEND) modeReg <= iMODE;
      if (state == SEND && expiry)            overrunReg <= 1'b1;
    end
  end

  // Word index, channel and frame counters advance on accepted words
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wordIdx  <= '0;
      chReg    <= '0;
      frameCnt <= '0;
    end else if (xfer) begin
      if (lastWord) begin
        wordIdx  <= '0;
        chReg    <= chReg + CH_W'(1);
        frameCnt <= frameCnt + PAY_W'(1);
      end else begin
        wordIdx  <= wordIdx + IDX_W'(1);
      end
    end
  end

`ifdef BLVDS_STIM_CHECKSUM_EN
  // Running payload sum, restarted after each frame
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)                sumReg <= '0;
    else if (xfer && lastWord) sumReg <= '0;
    else if (xfer)             sumReg <= sumReg + payload;
  end
`endif

  assign oVALID      = (state == SEND);
  assign oDATA       = oVALID ? {chReg, payloadOut} : '0;
  assign oSOF        = oVALID && (wordIdx == '0);
  assign oEOF        = oVALID && lastWord;
  assign oCH         = chReg;
  assign oOVERRUN    = overrunReg;
  assign oFRAME_INIT = frameInit;

endmodule

// File: doc/blvds_stim_gen.md
BLVDS_STIM_GEN -- requirements
Module: blvds_stim_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 18: output word width.
REQ-002 SHALL have parameter PERIOD_W, default 26: frame-period counter width.
REQ-003 SHALL have parameter FRAME_LEN, default 16: payload words per frame, range 1..255.
REQ-004 SHALL have parameter CH_NUM, default 4: channel count, a power of two from 2 to 16; CH_W = log2(CH_NUM).
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port iRESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port iENA, input, 1 bit: generation enable.
REQ-008 SHALL have port iPERIOD, input, PERIOD_W bits: clock cycles between frame starts; 0 means no frames.
REQ-009 SHALL have port iMODE, input, 2 bits: payload pattern select.
REQ-010 SHALL have port iREADY, input, 1 bit: downstream accept.
REQ-011 SHALL have port oFRAME_INIT, output, 1 bit: one-cycle pulse at each period expiry.
REQ-012 SHALL have port oDATA, output, DATA_W bits: data word.
REQ-013 SHALL have port oVALID, output, 1 bit: oDATA is valid.
REQ-014 SHALL have port oSOF / oEOF, output, 1 bit each: first / last word of a frame, qualified by oVALID.
REQ-015 SHALL have port oCH, output, CH_W bits: channel of the current frame.
REQ-016 SHALL have port oOVERRUN, output, 1 bit: sticky period-overrun flag.

Function
REQ-017 SHALL implement the states IDLE, COUNT and SEND.
REQ-018 IDLE SHALL go to COUNT when iENA=1 and iPERIOD!=0; the period counter clears on entry.
REQ-019 COUNT SHALL increment the period counter each cycle; at count = iPERIOD-1 it SHALL pulse oFRAME_INIT for one cycle, clear the counter and enter SEND on the next cycle.
REQ-020 The period counter SHALL keep running during SEND, so frame starts stay periodic regardless of backpressure.
REQ-021 SEND SHALL present FRAME_LEN words with valid/ready semantics.
REQ-022 A word transfers when oVALID=1 and iREADY=1.
REQ-023 While oVALID=1 and iREADY=0, oDATA, oSOF, oEOF and oCH SHALL hold stable.
REQ-024 oSOF SHALL be 1 on word 0; oEOF SHALL be 1 on the last word; both SHALL be 1 on the same word when FRAME_LEN=1.
REQ-025 oDATA SHALL be {oCH, payload}, where payload is DATA_W-CH_W bits.
REQ-026 iMODE=0: payload = word index.
REQ-027 iMODE=1: payload = frame counter (wraps modulo 2^(DATA_W-CH_W)).
REQ-028 iMODE=2: payload = alternating 1010... and 0101... on even and odd words.
REQ-029 iMODE=3: payload = one-hot bit (word index mod payload width).
REQ-030 iMODE SHALL be sampled only at frame start and held for the whole frame.
REQ-031 After the last word transfers, the FSM SHALL return to COUNT, or to IDLE if iENA=0.
REQ-032 After the last word transfers, oCH SHALL increment modulo CH_NUM (CH_NUM-1 wraps to 0) and the frame counter SHALL increment.
REQ-033 A period expiry during SEND SHALL still pulse oFRAME_INIT, set oOVERRUN, and drop that frame; the current frame completes normally.
REQ-034 oOVERRUN SHALL clear only on reset.
REQ-035 iENA=0 during SEND SHALL finish the frame and then go to IDLE; iENA=0 during COUNT SHALL go to IDLE immediately.
REQ-036 iPERIOD SHALL be sampled when IDLE is left.
REQ-037 iPERIOD changes during COUNT or SEND SHALL take effect at the next IDLE exit.

Reset
REQ-038 On iRESET=1, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-039 On iRESET=1, oFRAME_INIT, oVALID, oSOF, oEOF and oOVERRUN SHALL be 0, oDATA SHALL be 0 and oCH SHALL be 0.
REQ-040 A reset asserted mid-frame SHALL abort the frame with no partial oEOF.

Configuration
REQ-041 With BLVDS_STIM_CHECKSUM_EN defined, every frame SHALL carry one extra final word {oCH, sum}, where sum is the modulo-2^(DATA_W-CH_W) sum of the frame's payloads; oEOF moves to this word.
REQ-042 Without BLVDS_STIM_CHECKSUM_EN, frames SHALL be exactly FRAME_LEN words and the checksum logic SHALL be absent.

Verification
REQ-043 Use DATA_W=18, CH_NUM=4, FRAME_LEN=4, iPERIOD=20, iMODE=0, iREADY=1: oFRAME_INIT SHALL pulse every 20 cycles; oDATA SHALL be 0x00000..0x00003, then 0x10000..0x10003 for channel 1; oCH SHALL reach 3 and then wrap to 0.
REQ-044 Drive iREADY with a 1-of-3 duty cycle: no word is lost or duplicated; oDATA holds while stalled.
REQ-045 Use iPERIOD=6, FRAME_LEN=4, iREADY=0 for 10 cycles: oOVERRUN SHALL be set, one frame SHALL be dropped, and the current frame SHALL complete.
REQ-046 Use iMODE=3: payload SHALL be 0x0001, 0x0002, 0x0004, 0x0008; iMODE changed mid-frame SHALL have no effect until the next frame.
REQ-047 Assert iRESET during word 2: all outputs SHALL be 0 next cycle; the first frame after release SHALL start on oCH=0 with oSOF=1.
REQ-048 With BLVDS_STIM_CHECKSUM_EN and iMODE=0: a 5th word 0x00006 SHALL carry oEOF=1.
